operand_dispatch: RTL and testbench

OPERAND_DISPATCH -- requirements
Module: operand_dispatch

---
 rtl/mxv_pkg.sv | 14 +
 rtl/lane_rr_ptr.sv | 33 +++
 rtl/operand_dispatch.sv | 121 ++++++++++++
 tb/tb_operand_dispatch.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// Shared types and constants for the operand dispatcher and its lane pointer.
package mxv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/lane_rr_ptr.sv
// Round-robin lane pointer: clears to lane 0, advances one lane per request, wraps 3 -> 0.
module lane_rr_ptr
  import mxv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       adv,
  output logic [1:0] ptr
);

  lane_idx_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = ptr_q + lane_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/operand_dispatch.sv
// Splits an operand stream across four lane FIFOs in strict round-robin order, one job at a time.
// Optional stall counter output is enabled by defining DISPATCH_STALL_CNT_EN.
module operand_dispatch
  import mxv_pkg::*;
#(
  parameter int Size  = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] job_len,
  input  logic [Size-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] full,
  output logic [LANES-1:0] push,
  output logic [Size-1:0]  push_data,
  output logic             busy,
  output logic             done
`ifdef DISPATCH_STALL_CNT_EN
  ,
  output logic [7:0]       stall_cnt
`endif
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [LANES-1:0] push_q, push_d;
  logic [Size-1:0]  data_q, data_d;
  logic [1:0]       lane_ptr;
  logic             start_acc;
  logic             accept;

  assign start_acc = (state_q == IDLE) && start;
  assign in_ready  = (state_q == RUN) && !full[lane_ptr] && (remain_q != '0);
  assign accept    = in_valid && in_ready;

  lane_rr_ptr u_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .adv   (accept),
    .ptr   (lane_ptr)
  );

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    push_d   = '0;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          remain_d = job_len;
          state_d  = (job_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          push_d   = LANES'(1) << lane_ptr;
          data_d   = in_data;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      remain_q <= '0;
      push_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      push_q   <= push_d;
      data_q   <= data_d;
    end
  end

  assign push      = push_q;
  assign push_data = data_q;
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);

`ifdef DISPATCH_STALL_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] stall_q, stall_d;

  // Counts cycles where an offered operand is blocked by a full target lane.
  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if ((state_q == RUN) && in_valid && full[lane_ptr]) begin
      stall_d = sat_inc8(stall_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_operand_dispatch.sv
// Self-checking bench for operand_dispatch: directed scenarios plus randomized traffic against a job-level model.
module tb_operand_dispatch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] job_len = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] full = '0;
  logic [3:0] push;
  logic [7:0] push_data;
  logic       busy;
  logic       done;
`ifdef DISPATCH_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Job-level reference model: a job is "running" while operands remain,
  // the lane served is simply (operands served so far) mod 4.
  bit         m_job = 0;
  bit         m_done = 0;
  int         m_left = 0;
  int         m_served = 0;
  logic [3:0] e_push = '0;
  logic [7:0] e_data = '0;
  int         e_stall = 0;

  operand_dispatch #(.Size(8), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .job_len   (job_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .full      (full),
    .push      (push),
    .push_data (push_data),
    .busy      (busy),
    .done      (done)
`ifdef DISPATCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return m_job && (m_left > 0) && !full[m_served % 4];
  endfunction

  task automatic model_update();
    int lane;
    if (reset) begin
      m_job = 0; m_done = 0; m_left = 0; m_served = 0;
      e_push = '0; e_data = '0; e_stall = 0;
      return;
    end
    e_push = '0;
    if (m_done) begin
      m_done = 0;
    end else if (!m_job) begin
      if (start) begin
        e_stall = 0;
        if (job_len == 0) m_done = 1;
        else begin
          m_job = 1; m_left = int'(job_len); m_served = 0;
        end
      end
    end else begin
      lane = m_served % 4;
      if (in_valid && full[lane]) e_stall = (e_stall >= 255) ? 255 : e_stall + 1;
      if (in_valid && !full[lane]) begin
        e_push = 4'(1 << lane);
        e_data = in_data;
        m_served++;
        m_left--;
        if (m_left == 0) begin
          m_job = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; full = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; job_len = 4'd3; in_valid = 1'b1; in_data = 8'hA5; full = '0;
    tick();
    tick();
    n_cmp++;
    if ({push, push_data, busy, done} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_out: got push=%b data=%h busy=%b done=%b, want all zero", push, push_data, busy, done);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", in_ready);
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0] d [5];
    do_reset();
    start = 1'b1; job_len = 4'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d[i] = 8'($urandom);
      in_valid = 1'b1; in_data = d[i];
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      n_cmp++;
      if ({push, push_data} !== {4'(1 << (i % 4)), d[i]}) begin
        n_bad++;
        $display("FAIL stream_push[%0d]: got %b/%h want %b/%h", i, push, push_data, 4'(1 << (i % 4)), d[i]);
      end
      n_cmp++;
      if ({busy, done} !== {1'b1, (i == 4)}) begin
        n_bad++;
        $display("FAIL stream_flags[%0d]: got busy=%b done=%b want busy=1 done=%b", i, busy, done, (i == 4));
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({push, busy, done} !== 6'd0) begin
      n_bad++;
      $display("FAIL stream_end: got push=%b busy=%b done=%b want 0/0/0", push, busy, done);
    end
  endtask

  task automatic test_stall();
    logic [3:0] want;
    do_reset();
    start = 1'b1; job_len = 4'd4;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 8'(8'h10 + i);
      tick();
    end
    full = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h55;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      n_cmp++;
      if (push !== 4'b0000 || push_data !== 8'h11) begin
        n_bad++;
        $display("FAIL stall_push[%0d]: got %b/%h want 0000/11", i, push, push_data);
      end
    end
    full = 4'b0000;
    for (int i = 2; i < 4; i++) begin
      in_data = 8'(8'h10 + i);
      tick();
      want = 4'(1 << i);
      n_cmp++;
      if ({push, push_data, done} !== {want, 8'(8'h10 + i), (i == 3)}) begin
        n_bad++;
        $display("FAIL stall_order[%0d]: got %b/%h done=%b want %b/%h done=%b", i, push, push_data, done, want, 8'(8'h10 + i), (i == 3));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_zero_len();
    do_reset();
    start = 1'b1; job_len = 4'd0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({push, in_ready, busy, done} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL zero_len_done: got push=%b rdy=%b busy=%b done=%b want 0000/0/1/1", push, in_ready, busy, done);
    end
    tick();
    n_cmp++;
    if ({push, in_ready, busy, done} !== 7'd0) begin
      n_bad++;
      $display("FAIL zero_len_after: got push=%b rdy=%b busy=%b done=%b want all 0", push, in_ready, busy, done);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    start = 1'b1; job_len = 4'd6;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({push, busy, done, in_ready} !== 7'd0) begin
      n_bad++;
      $display("FAIL midreset_out: got push=%b busy=%b done=%b rdy=%b want all 0", push, busy, done, in_ready);
    end
    reset = 1'b0; in_valid = 1'b0;
    start = 1'b1; job_len = 4'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
    tick();
    n_cmp++;
    if ({push, push_data, done} !== {4'b0001, 8'hC3, 1'b1}) begin
      n_bad++;
      $display("FAIL midreset_restart: got %b/%h done=%b want 0001/c3 done=1", push, push_data, done);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    int pushes;
    int done_at;
    pushes = 0; done_at = -1;
    do_reset();
    start = 1'b1; job_len = 4'd3;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = 8'(c);
      start = (c == 1);
      job_len = 4'd9;
      tick();
      if (push != 4'b0000) pushes++;
      if (done === 1'b1) done_at = c;
    end
    start = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (pushes !== 3) begin
      n_bad++;
      $display("FAIL start_ignored_count: got %0d pushes want 3", pushes);
    end
    n_cmp++;
    if (done_at !== 2) begin
      n_bad++;
      $display("FAIL start_ignored_done: got done at step %0d want 2", done_at);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset    = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 5) == 0);
      job_len  = 4'($urandom_range(0, 15));
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom);
      full     = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      #1;
      n_cmp++;
      if (in_ready !== exp_ready()) begin
        n_bad++;
        $display("FAIL rand_ready cyc %0d: got %b want %b", c, in_ready, exp_ready());
      end
      tick();
      n_cmp++;
      if ({push, push_data, busy, done} !== {e_push, e_data, (m_job | m_done), m_done}) begin
        n_bad++;
        $display("FAIL rand_out cyc %0d: got push=%b data=%h busy=%b done=%b want push=%b data=%h busy=%b done=%b",
                 c, push, push_data, busy, done, e_push, e_data, (m_job | m_done), m_done);
      end
`ifdef DISPATCH_STALL_CNT_EN
      n_cmp++;
      if (stall_cnt !== 8'(e_stall)) begin
        n_bad++;
        $display("FAIL rand_stall cyc %0d: got %0d want %0d", c, stall_cnt, e_stall);
      end
`endif
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; full = '0;
    tick();
  endtask

`ifdef DISPATCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    start = 1'b1; job_len = 4'd2;
    tick();
    start = 1'b0; in_valid = 1'b1; full = 4'hF;
    for (int i = 0; i < 300; i++) tick();
    n_cmp++;
    if (stall_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL stallcnt_sat: got %0d want 255", stall_cnt);
    end
    full = 4'h0;
    tick(); tick(); tick();
    in_valid = 1'b0;
    n_cmp++;
    if (stall_cnt !== 8'd255 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stallcnt_hold: got cnt=%0d busy=%b want 255/0", stall_cnt, busy);
    end
    start = 1'b1; job_len = 4'd1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (stall_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL stallcnt_clear: got %0d want 0", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_zero_len();
    test_mid_reset();
    test_start_ignored();
    test_random();
`ifdef DISPATCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
